approx_mul_err_sweeper: RTL and testbench

- Hardware sequencer that sweeps every operand pair through one approximate recursive multiplier instance (e.g. the Kulkarni 8x8) and checks each product against the exact product.
- Accumulates error statistics on the fly: erroneous-result count, sum of error distances, max error distance and the operands that produced it.
- Sits beside the multiplier under test as its only operand driver. Used for on-chip/FPGA characterization, replacing the 65536-step simulation loop.

---
 rtl/approx_mul_err_sweeper.sv | 233 +++++++++++++++++++++++
 tb/tb_approx_mul_err_sweeper.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_err_sweeper.sv
// Exhaustive error characterisation sequencer for an approximate multiplier.
// Drives every operand pair into the attached multiplier, one per cycle.
// Compares each returned product against an internally computed exact product.
// Accumulates error count, error-distance sum, max error distance and its operands.
module approx_mul_err_sweeper #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_y,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [2*WIDTH:0]     err_count,
    output logic [4*WIDTH-1:0]   sum_ed,
    output logic [2*WIDTH-1:0]   max_ed,
    output logic [WIDTH-1:0]     worst_a,
    output logic [WIDTH-1:0]     worst_b
);

    localparam int         PW         = 2 * WIDTH;
    localparam logic [1:0] DRAIN_LAST = 2'(MUL_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ABORT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] drain_cnt;
    logic       accept;
    logic       last_pair;
    logic       flush;
    logic       vld_p0;

    // Absolute difference between exact and returned product.
    function automatic logic [PW-1:0] err_dist(input logic [PW-1:0] exp_v,
                                               input logic [PW-1:0] got_v);
        return (exp_v >= got_v) ? (exp_v - got_v) : (got_v - exp_v);
    endfunction

    assign accept    = (state == S_IDLE) && start;
    assign last_pair = (mul_a == '1) && (mul_b == '1);
    // Leaving for ABORT throws away every entry still in the check pipeline.
    assign flush     = (state_next == S_ABORT);
    assign vld_p0    = (state == S_RUN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode; abort outranks the RUN->DRAIN step.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        aborted    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = S_ABORT;
                end else if (last_pair) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = S_ABORT;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            S_ABORT: begin
                aborted    = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Counts DRAIN cycles so the last pair gets MUL_LAT+1 edges to be accounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= 2'd0;
        end else if (state == S_DRAIN) begin
            drain_cnt <= drain_cnt + 2'd1;
        end else begin
            drain_cnt <= 2'd0;
        end
    end

    // Operand generator: {a,b} behaves as one counter, b in the low half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (accept) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if ((state == S_RUN) && !abort && !last_pair) begin
            {mul_a, mul_b} <= {mul_a, mul_b} + PW'(1);
        end
    end

    // ---- stage p1: operands aligned with mul_y ----
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic             vld_p1;
    logic [PW-1:0]    exact_p1;

    if (MUL_LAT == 0) begin : g_comb
        assign a_p1   = mul_a;
        assign b_p1   = mul_b;
        assign vld_p1 = vld_p0;
    end else begin : g_dly
        logic [WIDTH-1:0] a_dly   [MUL_LAT];
        logic [WIDTH-1:0] b_dly   [MUL_LAT];
        logic             vld_dly [MUL_LAT];

        // Operand delay line matching the multiplier latency.
        always_ff @(posedge clk) begin
            a_dly[0] <= mul_a;
            b_dly[0] <= mul_b;
            for (int i = 1; i < MUL_LAT; i++) begin
                a_dly[i] <= a_dly[i-1];
                b_dly[i] <= b_dly[i-1];
            end
        end

        // Valid delay line; cleared on abort so in-flight pairs are dropped.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < MUL_LAT; i++) begin
                    vld_dly[i] <= 1'b0;
                end
            end else begin
                vld_dly[0] <= vld_p0 && !flush;
                for (int i = 1; i < MUL_LAT; i++) begin
                    vld_dly[i] <= vld_dly[i-1] && !flush;
                end
            end
        end

        assign a_p1   = a_dly[MUL_LAT-1];
        assign b_p1   = b_dly[MUL_LAT-1];
        assign vld_p1 = vld_dly[MUL_LAT-1];
    end

    assign exact_p1 = PW'(a_p1) * PW'(b_p1);

    // ---- stage p2: compare register ----
    logic [WIDTH-1:0] a_p2;
    logic [WIDTH-1:0] b_p2;
    logic [PW-1:0]    y_p2;
    logic [PW-1:0]    exact_p2;
    logic [PW-1:0]    ed_p2;
    logic             vld_p2;

    // Capture approximate/exact products, their distance and the operands.
    always_ff @(posedge clk) begin
        a_p2     <= a_p1;
        b_p2     <= b_p1;
        y_p2     <= mul_y;
        exact_p2 <= exact_p1;
        ed_p2    <= err_dist(exact_p1, mul_y);
    end

    // Compare-stage valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1 && !flush;
        end
    end

    // ---- accumulate stage ----
    // Statistics: cleared by an accepted start, otherwise held between sweeps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            worst_a   <= '0;
            worst_b   <= '0;
        end else if (accept) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            worst_a   <= '0;
            worst_b   <= '0;
        end else if (vld_p2 && !flush) begin
            if (y_p2 != exact_p2) begin
                err_count <= err_count + (PW+1)'(1);
            end
            sum_ed <= sum_ed + (4*WIDTH)'(ed_p2);
            // Strictly greater: ties keep the earliest pair.
            if (ed_p2 > max_ed) begin
                max_ed  <= ed_p2;
                worst_a <= a_p2;
                worst_b <= b_p2;
            end
        end
    end

endmodule

// File: tb/tb_approx_mul_err_sweeper.sv
// Bench for approx_mul_err_sweeper: five 8-bit sweepers run in parallel against
// different multiplier models, plus a 4-bit, one-cycle-latency sweeper used for
// the abort, reset and start-filtering sequences.
module tb_approx_mul_err_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- multiplier models ----------------
    function automatic logic [3:0] kul2(input logic [1:0] a, input logic [1:0] b);
        logic [3:0] r;
        r = {2'b00, a} * {2'b00, b};
        if (a == 2'd3 && b == 2'd3) r = 4'd7;
        return r;
    endfunction

    function automatic logic [7:0] kul4(input logic [3:0] a, input logic [3:0] b);
        return {kul2(a[3:2], b[3:2]), 4'b0000}
             + {2'b00, kul2(a[3:2], b[1:0]), 2'b00}
             + {2'b00, kul2(a[1:0], b[3:2]), 2'b00}
             + {4'b0000, kul2(a[1:0], b[1:0])};
    endfunction

    function automatic logic [15:0] kul8(input logic [7:0] a, input logic [7:0] b);
        return {kul4(a[7:4], b[7:4]), 8'h00}
             + {4'h0, kul4(a[7:4], b[3:0]), 4'h0}
             + {4'h0, kul4(a[3:0], b[7:4]), 4'h0}
             + {8'h00, kul4(a[3:0], b[3:0])};
    endfunction

    function automatic logic [15:0] model8(input int m, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, a} * {8'd0, b};
        case (m)
            1: if (a == 8'd3 && b == 8'd3) p = 16'd7;
            2, 3: if ((a == 8'd2 && b == 8'd5) || (a == 8'd9 && b == 8'd1)) p = p + 16'd4;
            4: p = kul8(a, b);
            default: ;
        endcase
        return p;
    endfunction

    function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = {4'd0, a} * {4'd0, b};
        if (a == 4'd0 && b == 4'd0) p = 8'd1;
        if (a == 4'd5 && b == 4'd7) p = 8'd30;
        if (a == 4'd15 && b == 4'd15) p = 8'd220;
        return p;
    endfunction

    // ---------------- 8-bit group ----------------
    logic        rst_n_b, start_b, abort_b;
    logic [7:0]  ma [5];
    logic [7:0]  mb [5];
    logic [15:0] my [5];
    logic        bz [5];
    logic        dn [5];
    logic        ab [5];
    logic [16:0] ec [5];
    logic [31:0] se [5];
    logic [15:0] mx [5];
    logic [7:0]  wa [5];
    logic [7:0]  wb [5];

    for (genvar g = 0; g < 5; g++) begin : g_big
        logic [15:0] y_c;
        assign y_c = model8(g, ma[g], mb[g]);
        if (g == 3) begin : g_reg
            logic [15:0] y_r1, y_r2;
            always @(posedge clk) begin
                y_r1 <= y_c;
                y_r2 <= y_r1;
            end
            assign my[g] = y_r2;
        end else begin : g_wire
            assign my[g] = y_c;
        end
        approx_mul_err_sweeper #(.WIDTH(8), .MUL_LAT((g == 3) ? 2 : 0)) u_dut (
            .clk(clk), .rst_n(rst_n_b), .start(start_b), .abort(abort_b),
            .mul_a(ma[g]), .mul_b(mb[g]), .mul_y(my[g]),
            .busy(bz[g]), .done(dn[g]), .aborted(ab[g]),
            .err_count(ec[g]), .sum_ed(se[g]), .max_ed(mx[g]),
            .worst_a(wa[g]), .worst_b(wb[g])
        );
    end

    int c0_b = 0;
    int done_cnt [5] = '{default: 0};
    int done_at  [5] = '{default: 0};
    int busy_cnt [5] = '{default: 0};
    int abt_cnt  [5] = '{default: 0};

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (dn[i]) begin
                done_cnt[i] <= done_cnt[i] + 1;
                done_at[i]  <= cyc - c0_b;
            end
            if (bz[i]) busy_cnt[i] <= busy_cnt[i] + 1;
            if (ab[i]) abt_cnt[i] <= abt_cnt[i] + 1;
        end
    end

    // ---------------- 4-bit group ----------------
    logic       rst_s, start_s, abort_s;
    logic [3:0] sa, sb;
    logic [7:0] sy;
    logic       sbz, sdn, sab;
    logic [8:0] sec;
    logic [15:0] sse;
    logic [7:0] smx;
    logic [3:0] swa, swb;

    always @(posedge clk) sy <= model4(sa, sb);

    approx_mul_err_sweeper #(.WIDTH(4), .MUL_LAT(1)) u_small (
        .clk(clk), .rst_n(rst_s), .start(start_s), .abort(abort_s),
        .mul_a(sa), .mul_b(sb), .mul_y(sy),
        .busy(sbz), .done(sdn), .aborted(sab),
        .err_count(sec), .sum_ed(sse), .max_ed(smx),
        .worst_a(swa), .worst_b(swb)
    );

    int c0_s = 0;
    int s_done_cnt = 0, s_done_at = 0, s_busy_cnt = 0, s_abt_cnt = 0, s_order_err = 0;

    always @(negedge clk) begin
        if (sdn) begin
            s_done_cnt <= s_done_cnt + 1;
            s_done_at  <= cyc - c0_s;
        end
        if (sbz) s_busy_cnt <= s_busy_cnt + 1;
        if (sab) s_abt_cnt <= s_abt_cnt + 1;
        if (sbz && (cyc - c0_s) < 256 && {sa, sb} != 8'(cyc - c0_s))
            s_order_err <= s_order_err + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_small();
        tick();
        start_s = 1'b1;
        @(posedge clk);
        #1;
        c0_s    = cyc;
        start_s = 1'b0;
    endtask

    task automatic wait_small(input int base, input int bound);
        for (int k = 0; k < bound && s_done_cnt == base; k++) tick();
    endtask

    task automatic small_stats(input string nm, input int e, input int s, input int m,
                               input int a, input int b);
        chk({nm, "_err_count"}, sec, e);
        chk({nm, "_sum_ed"}, sse, s);
        chk({nm, "_max_ed"}, smx, m);
        chk({nm, "_worst_a"}, swa, a);
        chk({nm, "_worst_b"}, swb, b);
    endtask

    typedef struct {
        int          idx;
        logic [16:0] ec;
        logic [31:0] se;
        logic [15:0] mx;
        logic [7:0]  wa;
        logic [7:0]  wb;
        int          dat;
    } vec_t;

    vec_t        tbl [5];
    logic [16:0] k_ec;
    logic [31:0] k_se;
    logic [15:0] k_mx;
    logic [7:0]  k_wa, k_wb;
    int          bd, bb, ba, bo;
    int          bdone [5];
    int          bbusy [5];
    int          babt  [5];

    initial begin
        rst_n_b = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        rst_s   = 1'b0; start_s = 1'b0; abort_s = 1'b0;

        // Software tally of the Kul8 sweep, in issue order.
        k_ec = '0; k_se = '0; k_mx = '0; k_wa = '0; k_wb = '0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                logic [15:0] ex, ap, d;
                ex = 16'(a * b);
                ap = kul8(8'(a), 8'(b));
                d  = (ex >= ap) ? (ex - ap) : (ap - ex);
                if (d != 16'd0) k_ec = k_ec + 17'd1;
                k_se = k_se + 32'(d);
                if (d > k_mx) begin
                    k_mx = d; k_wa = 8'(a); k_wb = 8'(b);
                end
            end
        end

        tbl[0] = '{0, 17'd0, 32'd0, 16'd0, 8'd0, 8'd0, 65537};
        tbl[1] = '{1, 17'd1, 32'd2, 16'd2, 8'd3, 8'd3, 65537};
        tbl[2] = '{2, 17'd2, 32'd8, 16'd4, 8'd2, 8'd5, 65537};
        tbl[3] = '{3, 17'd2, 32'd8, 16'd4, 8'd2, 8'd5, 65539};
        tbl[4] = '{4, k_ec, k_se, k_mx, k_wa, k_wb, 65537};

        // Reset state.
        repeat (3) tick();
        chk("rst_s_busy", sbz, 0);
        chk("rst_s_mul_a", sa, 0);
        chk("rst_s_err_count", sec, 0);
        chk("rst_s_all_zero", |{sa, sb, sbz, sdn, sab, sec, sse, smx, swa, swb}, 0);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rst_big%0d_all_zero", i),
                |{ma[i], mb[i], bz[i], dn[i], ab[i], ec[i], se[i], mx[i], wa[i], wb[i]}, 0);
        rst_n_b = 1'b1;
        rst_s   = 1'b1;
        tick();

        // Small full sweep with a stray start pulse mid-run.
        bd = s_done_cnt; bb = s_busy_cnt; ba = s_abt_cnt; bo = s_order_err;
        start_small();
        repeat (50) tick();
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        wait_small(bd, 400);
        chk("s1_done_pulse", s_done_cnt - bd, 1);
        chk("s1_done_cycle", s_done_at, 258);
        chk("s1_busy_cycles", s_busy_cnt - bb, 258);
        chk("s1_no_abort", s_abt_cnt - ba, 0);
        chk("s1_issue_order", s_order_err - bo, 0);
        small_stats("s1", 3, 11, 5, 5, 7);
        chk("s1_hold_a", sa, 15);
        chk("s1_hold_b", sb, 15);
        tick();
        chk("s1_done_one_cycle", sdn, 0);
        chk("s1_held_sum", sse, 11);

        // Abort in IDLE is ignored.
        ba = s_abt_cnt;
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
        tick();
        chk("s2_idle_abort_ignored", s_abt_cnt - ba, 0);

        // Abort 100 cycles into RUN.
        bd = s_done_cnt;
        start_small();
        repeat (101) tick();
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
        chk("s2_aborted", sab, 1);
        chk("s2_busy_low", sbz, 0);
        chk("s2_no_done", sdn, 0);
        small_stats("s2", 2, 6, 5, 5, 7);
        tick();
        chk("s2_aborted_one_cycle", sab, 0);
        chk("s2_held_err_count", sec, 2);

        // start together with abort in IDLE: start wins, then a full sweep.
        tick();
        start_s = 1'b1;
        abort_s = 1'b1;
        @(posedge clk);
        #1;
        c0_s = cyc;
        start_s = 1'b0;
        abort_s = 1'b0;
        tick();
        chk("s2_start_wins", sbz, 1);
        chk("s2_stats_cleared", sec, 0);
        wait_small(bd, 400);
        chk("s2_done_pulse", s_done_cnt - bd, 1);
        chk("s2_done_cycle", s_done_at, 258);
        small_stats("s2_rerun", 3, 11, 5, 5, 7);

        // Abort on the final RUN cycle wins over the move to DRAIN.
        bd = s_done_cnt; ba = s_abt_cnt;
        start_small();
        repeat (256) tick();
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
        chk("s3_aborted", sab, 1);
        chk("s3_no_done", sdn, 0);
        chk("s3_err_count", sec, 2);
        chk("s3_sum_ed", sse, 6);
        repeat (4) tick();
        chk("s3_done_never", s_done_cnt - bd, 0);
        chk("s3_abort_once", s_abt_cnt - ba, 1);

        // Reset asserted mid-sweep.
        bd = s_done_cnt; ba = s_abt_cnt;
        start_small();
        repeat (50) tick();
        chk("s4_partial_err_count", sec, 1);
        rst_s = 1'b0;
        #1;
        chk("s4_reset_all_zero", |{sa, sb, sbz, sdn, sab, sec, sse, smx, swa, swb}, 0);
        tick();
        rst_s = 1'b1;
        repeat (5) tick();
        chk("s4_no_done", s_done_cnt - bd, 0);
        chk("s4_no_abort", s_abt_cnt - ba, 0);
        chk("s4_idle", sbz, 0);

        // 8-bit sweeps, all models in parallel, with an ignored start mid-run.
        for (int i = 0; i < 5; i++) begin
            bdone[i] = done_cnt[i];
            bbusy[i] = busy_cnt[i];
            babt[i]  = abt_cnt[i];
        end
        tick();
        start_b = 1'b1;
        @(posedge clk);
        #1;
        c0_b    = cyc;
        start_b = 1'b0;
        repeat (1000) tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 70000; k++) begin
            int nd;
            nd = 0;
            for (int i = 0; i < 5; i++) if (done_cnt[i] != bdone[i]) nd++;
            if (nd == 5) break;
            tick();
        end
        repeat (2) tick();
        for (int r = 0; r < 5; r++) begin
            int i;
            i = tbl[r].idx;
            chk($sformatf("big%0d_err_count", i), ec[i], tbl[r].ec);
            chk($sformatf("big%0d_sum_ed", i), se[i], tbl[r].se);
            chk($sformatf("big%0d_max_ed", i), mx[i], tbl[r].mx);
            chk($sformatf("big%0d_worst_a", i), wa[i], tbl[r].wa);
            chk($sformatf("big%0d_worst_b", i), wb[i], tbl[r].wb);
            chk($sformatf("big%0d_done_pulse", i), done_cnt[i] - bdone[i], 1);
            chk($sformatf("big%0d_done_cycle", i), done_at[i], tbl[r].dat);
            chk($sformatf("big%0d_busy_cycles", i), busy_cnt[i] - bbusy[i], tbl[r].dat);
            chk($sformatf("big%0d_no_abort", i), abt_cnt[i] - babt[i], 0);
            chk($sformatf("big%0d_hold_ab", i), {ma[i], mb[i]}, 16'hFFFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
